// File: rtl/lac_phase_tracker.sv
// Slow-clock phase tracker: synchronises clock_lac, runs a flywheel
// phase counter, qualifies lock and emits a phase-selected strobe.
module lac_phase_tracker #(
  parameter int RATIO       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int MISS_LIMIT  = 2,
  parameter int ERR_CNT_W   = 8,
  localparam int PW = (RATIO > 2) ? $clog2(RATIO) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clock_lac,
  input  logic [PW-1:0]        strobe_phase,
  output logic [PW-1:0]        phase,
  output logic                 strobe,
  output logic                 locked,
  output logic                 edge_err,
  output logic [ERR_CNT_W-1:0] unlock_count
);

  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(RATIO - 1);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lac_dly_q, lac_dly_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [GW-1:0]          good_q, good_d;
  logic [MW-1:0]          miss_q, miss_d;
  logic [ERR_CNT_W-1:0]   unlock_q, unlock_d;
  logic                   strobe_q, strobe_d;
  logic                   err_q, err_d;

  logic          sync_out;
  logic          rise;
  logic          ph_zero;
  logic          active;
  logic          good_ev;
  logic          bad_ev;
  logic [PW-1:0] phase_inc;

  // Synchroniser shift and one-cycle delay for rising-edge detection
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], clock_lac};
    lac_dly_d = sync_q[SYNC_STAGES-1];
  end

  // Edge and event classification against the flywheel phase
  always_comb begin
    sync_out  = sync_q[SYNC_STAGES-1];
    rise      = sync_out & ~lac_dly_q;
    ph_zero   = (phase_q == '0);
    active    = (state_q != HUNT);
    good_ev   = active & rise & ph_zero;
    bad_ev    = active & (rise ^ ph_zero);
    phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
  end

  // Next-state, phase, lock qualification and unlock counting
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    good_d   = good_q;
    miss_d   = miss_q;
    unlock_d = unlock_q;
    unique case (state_q)
      HUNT: begin
        phase_d = '0;
        if (rise) begin
          state_d = VERIFY;
          phase_d = PH_ONE;
          good_d  = '0;
        end
      end
      VERIFY: begin
        phase_d = phase_inc;
        unique case (1'b1)
          good_ev: begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              miss_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end
          (bad_ev & rise): begin
            phase_d = PH_ONE;
            good_d  = '0;
          end
          (bad_ev & ~rise): begin
            state_d = HUNT;
            phase_d = '0;
          end
          default: ;
        endcase
      end
      LOCKED: begin
        phase_d = phase_inc;
        unique case (1'b1)
          good_ev: miss_d = '0;
          bad_ev: begin
            if (miss_q == MISS_LAST) begin
              state_d = HUNT;
              phase_d = '0;
              miss_d  = '0;
              if (~&unlock_q) begin
                unlock_d = unlock_q + 1'b1;
              end
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: begin
        state_d = HUNT;
        phase_d = '0;
      end
    endcase
  end

  // Registered strobe and error pulse
  always_comb begin
    strobe_d = (state_q == LOCKED) & (phase_q == strobe_phase);
    err_d    = bad_ev;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      sync_q    <= '0;
      lac_dly_q <= 1'b0;
      phase_q   <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      unlock_q  <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      lac_dly_q <= lac_dly_d;
      phase_q   <= phase_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      unlock_q  <= unlock_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign phase        = phase_q;
  assign strobe       = strobe_q;
  assign locked       = (state_q == LOCKED);
  assign edge_err     = err_q;
  assign unlock_count = unlock_q;

endmodule

// File: tb/tb_lac_phase_tracker.sv
// Bench for lac_phase_tracker: random and shaped clock_lac stimulus
// compared every cycle with a behavioural model.
module tb_lac_phase_tracker;

  localparam int RATIO = 4;
  localparam int S     = 2;
  localparam int LC    = 8;
  localparam int ML    = 2;
  localparam int EW    = 2;
  localparam int PW    = 2;
  localparam int UMAX  = (1 << EW) - 1;
  localparam int H = 0, V = 1, L = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clock_lac = 1'b0;
  logic [PW-1:0] strobe_phase = '0;
  logic [PW-1:0] phase;
  logic          strobe;
  logic          locked;
  logic          edge_err;
  logic [EW-1:0] unlock_count;
  logic [6:0]    dut_vec;

  bit clk_run = 1'b1;
  int checks = 0;
  int errors = 0;

  int m_state, m_phase, m_good, m_miss, m_unl;
  bit m_strobe, m_err, m_locked;
  bit hq[$];
  bit stim[$];

  lac_phase_tracker #(
    .RATIO(RATIO), .SYNC_STAGES(S), .LOCK_COUNT(LC),
    .MISS_LIMIT(ML), .ERR_CNT_W(EW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clock_lac(clock_lac),
    .strobe_phase(strobe_phase), .phase(phase), .strobe(strobe),
    .locked(locked), .edge_err(edge_err), .unlock_count(unlock_count)
  );

  assign dut_vec = {phase, strobe, locked, edge_err, unlock_count};

  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  function automatic void m_reset();
    m_state = H; m_phase = 0; m_good = 0; m_miss = 0; m_unl = 0;
    m_strobe = 0; m_err = 0; m_locked = 0;
    hq.delete();
    for (int i = 0; i <= S; i++) hq.push_back(1'b0);
  endfunction

  // hq[0] is the previous cycle's input; a rise is visible S cycles later
  function automatic void m_step(bit x, int sp);
    bit rise, ph0, good, bad;
    int ns, np;
    rise = hq[S-1] && !hq[S];
    ph0  = (m_phase == 0);
    good = (m_state != H) && rise && ph0;
    bad  = (m_state != H) && (rise != ph0);
    m_strobe = (m_state == L) && (m_phase == sp);
    m_err    = bad;
    np = (m_state == H) ? 0 : (m_phase + 1) % RATIO;
    ns = m_state;
    if (m_state == H) begin
      if (rise) begin ns = V; np = 1; m_good = 0; end
    end else if (m_state == V) begin
      if (good) begin
        if (m_good == LC - 1) begin ns = L; m_miss = 0; end
        else m_good++;
      end else if (bad && rise) begin
        np = 1; m_good = 0;
      end else if (bad) begin
        ns = H; np = 0;
      end
    end else begin
      if (good) m_miss = 0;
      else if (bad) begin
        if (m_miss == ML - 1) begin
          ns = H; np = 0; m_miss = 0;
          if (m_unl < UMAX) m_unl++;
        end else m_miss++;
      end
    end
    m_state = ns; m_phase = np; m_locked = (ns == L);
    hq.push_front(x);
    void'(hq.pop_back());
  endfunction

  function automatic logic [6:0] m_vec();
    return {PW'(m_phase), m_strobe, m_locked, m_err, EW'(m_unl)};
  endfunction

  task automatic tick(input bit x);
    clock_lac = x;
    @(posedge clock);
    m_step(x, int'(strobe_phase));
    #1;
  endtask

  task automatic push_wave(input int hi, input int lo);
    repeat (hi) stim.push_back(1'b1);
    repeat (lo) stim.push_back(1'b0);
  endtask

  task automatic test_reset();
    m_reset();
    #12;
    checks++;
    if (dut_vec !== 7'd0) begin
      errors++;
      $display("FAIL reset_vec got %b want %b", dut_vec, 7'd0);
    end
    reset_n = 1'b1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_locked got %b want 0", locked);
    end
  endtask

  task automatic test_lock();
    int lock_at, nerr;
    lock_at = -1; nerr = 0;
    stim.delete();
    repeat (10) push_wave(2, 2);
    foreach (stim[i]) begin
      tick(stim[i]);
      if (locked && lock_at < 0) lock_at = i;
      if (edge_err) nerr++;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL lock t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
    checks++;
    if (lock_at !== 34) begin
      errors++;
      $display("FAIL lock_time got %0d want 34", lock_at);
    end
    checks++;
    if (nerr !== 0) begin
      errors++;
      $display("FAIL lock_errs got %0d want 0", nerr);
    end
  endtask

  task automatic test_strobe();
    int nstb;
    for (int k = 0; k < 4; k++) begin
      strobe_phase = PW'($urandom_range(0, RATIO - 1));
      stim.delete();
      repeat (4) push_wave(2, 2);
      nstb = 0;
      foreach (stim[i]) begin
        tick(stim[i]);
        if (i >= 8 && strobe) nstb++;
        checks++;
        if (dut_vec !== m_vec()) begin
          errors++;
          $display("FAIL strobe sp%0d t%0d got %b want %b",
                   strobe_phase, i, dut_vec, m_vec());
        end
      end
      checks++;
      if (nstb !== 2) begin
        errors++;
        $display("FAIL strobe_rate got %0d want 2", nstb);
      end
    end
  endtask

  task automatic test_missing();
    int nerr;
    nerr = 0;
    stim.delete();
    push_wave(2, 2); push_wave(2, 2);
    push_wave(0, 4);
    repeat (3) push_wave(2, 2);
    foreach (stim[i]) begin
      tick(stim[i]);
      if (edge_err) nerr++;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL miss1 t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || nerr !== 1) begin
      errors++;
      $display("FAIL miss1_hold got locked=%b errs=%0d want 1/1",
               locked, nerr);
    end
    stim.delete();
    push_wave(0, 4); push_wave(0, 4);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL miss2 t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
    checks++;
    if ({locked, phase, unlock_count} !== {1'b0, 2'd0, 2'd1}) begin
      errors++;
      $display("FAIL miss2_unlock got l=%b p=%0d u=%0d want 0/0/1",
               locked, phase, unlock_count);
    end
  endtask

  task automatic test_jitter();
    int len;
    stim.delete();
    for (int p = 0; p < 40; p++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : 4;
      push_wave(2, len - 2);
    end
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL jitter t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_reset_midlock();
    int lock_at;
    stim.delete();
    repeat (11) push_wave(2, 2);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL relock t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_state got %b want 1", locked);
    end
    @(negedge clock);
    clk_run = 1'b0;
    #20;
    reset_n = 1'b0;
    clock_lac = 1'b0;
    #3;
    checks++;
    if (dut_vec !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got %b want %b", dut_vec, 7'd0);
    end
    m_reset();
    #5 reset_n = 1'b1;
    #5 clk_run = 1'b1;
    lock_at = -1;
    stim.delete();
    repeat (10) push_wave(2, 2);
    foreach (stim[i]) begin
      tick(stim[i]);
      if (locked && lock_at < 0) lock_at = i;
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL post_reset t%0d got %b want %b",
                 i, dut_vec, m_vec());
      end
    end
    checks++;
    if (lock_at !== 34) begin
      errors++;
      $display("FAIL post_reset_lock got %0d want 34", lock_at);
    end
  endtask

  task automatic test_unlock_sat();
    int exp_unl[5] = '{1, 2, 3, 3, 3};
    for (int n = 0; n < 5; n++) begin
      stim.delete();
      repeat (10) push_wave(2, 2);
      push_wave(0, 4); push_wave(0, 4);
      foreach (stim[i]) begin
        tick(stim[i]);
        checks++;
        if (dut_vec !== m_vec()) begin
          errors++;
          $display("FAIL sat%0d t%0d got %b want %b",
                   n, i, dut_vec, m_vec());
        end
      end
      checks++;
      if (int'(unlock_count) !== exp_unl[n]) begin
        errors++;
        $display("FAIL sat_count%0d got %0d want %0d",
                 n, unlock_count, exp_unl[n]);
      end
    end
  endtask

  task automatic test_noise();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) strobe_phase = PW'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec !== m_vec()) begin
        errors++;
        $display("FAIL noise t%0d got %b want %b", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_strobe();
    test_missing();
    test_jitter();
    test_reset_midlock();
    test_unlock_sat();
    test_noise();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
